// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;
  localparam int unsigned WORDS_W = 32;
  typedef logic [WORDS_W-1:0] words_t;
endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Small register-array circular buffer; head is visible the cycle after push.
// Caller guarantees no push when full and no pop when empty.
module stream_buf #(
  parameter int dta_width = 8,
  parameter int buf_aw    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [dta_width-1:0] push_dat,
  input  logic                 pop,
  output logic [buf_aw:0]      count,
  output logic [dta_width-1:0] head
);
  localparam int depth = 1 << buf_aw;
  localparam logic [buf_aw-1:0] ptr_one = {{(buf_aw-1){1'b0}}, 1'b1};
  localparam logic [buf_aw:0]   cnt_one = {{buf_aw{1'b0}}, 1'b1};

  logic [dta_width-1:0] mem [depth];
  logic [buf_aw-1:0]    wr_ptr;
  logic [buf_aw-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + ptr_one;
      end
      if (pop) rd_ptr <= rd_ptr + ptr_one;
      case ({push, pop})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a fifo_sc read port into a ready/valid stream; FIFO word to dout in 2 cycles.
// Reads are issued only when a buffer slot is guaranteed, so dout_ready low stalls reads.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int dta_width = 8,
  parameter int buf_aw    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dta_width-1:0] fifo_dout,
  input  logic                 fifo_empty,
  input  logic                 fifo_valid,
  input  logic                 fifo_underflow,
  output logic                 fifo_rd_en,
  output logic [dta_width-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 err,
  output logic [31:0]          words
);
  localparam logic [buf_aw:0]   depth_n = {1'b1, {buf_aw{1'b0}}};
  localparam logic [buf_aw+1:0] depth_w = {2'b01, {buf_aw{1'b0}}};
  localparam words_t            words_one = 1;

  logic [buf_aw:0]   count;
  logic [buf_aw+1:0] credit;
  logic              pending;
  logic              rst_q;
  logic              pop;
  logic              push;

  assign dout_valid = (count != '0);
  assign pop        = dout_valid & dout_ready;

  // Words held plus the word in flight, minus the one leaving this cycle.
  assign credit = {1'b0, count}
                + {{(buf_aw+1){1'b0}}, pending}
                - {{(buf_aw+1){1'b0}}, pop};
  assign fifo_rd_en = ~rst & ~fifo_empty & (credit < depth_w);

  // Data in the cycle after reset belongs to a read issued before it.
  assign push = fifo_valid & ~rst_q & (count < depth_n);

  stream_buf #(
    .dta_width (dta_width),
    .buf_aw    (buf_aw)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (fifo_dout),
    .pop      (pop),
    .count    (count),
    .head     (dout)
  );

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      pending <= 1'b0;
      err     <= 1'b0;
      words   <= '0;
    end else begin
      pending <= fifo_rd_en;
      if (~rst_q & (fifo_underflow | (fifo_valid & ~pending))) err <= 1'b1;
      if (pop) words <= words + words_one;
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: cycle table, directed corner sequences, random traffic vs. a queue model.
module tb_fifo_rd_stream;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_valid;
  logic        fifo_underflow;
  logic        fifo_rd_en;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        err;
  logic [31:0] words;

  fifo_rd_stream #(.dta_width(8), .buf_aw(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_dout      (fifo_dout),
    .fifo_empty     (fifo_empty),
    .fifo_valid     (fifo_valid),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .err            (err),
    .words          (words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic       empty;
    logic       rdy;
    logic       vld;
    logic [7:0] dat;
    logic       unf;
    logic       e_rd;
    logic       e_dv;
    logic [7:0] e_dout;
    logic       e_err;
    logic [31:0] e_words;
  } vec_t;

  vec_t tbl [9];

  // Environment: FIFO model plus expected-stream scoreboard.
  logic [7:0]  fq[$];
  logic [7:0]  exp_q[$];
  logic        rst_drv = 1'b0;
  logic        rdy_drv = 1'b1;
  logic        inj_vld = 1'b0;
  logic [7:0]  inj_dat = '0;
  logic        inj_unf = 1'b0;
  logic        rd_prev = 1'b0;
  logic        after_rst = 1'b0;
  logic        exp_err = 1'b0;
  int unsigned exp_words = 0;
  int          n_reads = 0;
  int          n_pops = 0;
  int          cyc = 0;
  int          first_pop = -1;
  int          last_pop = -1;

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 8'(i));
      exp_q.push_back(base + 8'(i));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    rst = rst_drv;
    fifo_valid = 1'b0;
    fifo_underflow = 1'b0;
    fifo_dout = '0;
    if (inj_vld) begin
      fifo_valid = 1'b1;
      fifo_dout = inj_dat;
      inj_vld = 1'b0;
    end else if (rd_prev) begin
      if (fq.size() != 0) begin
        fifo_valid = 1'b1;
        fifo_dout = fq.pop_front();
      end else fifo_underflow = 1'b1;
    end
    if (inj_unf) begin
      fifo_underflow = 1'b1;
      inj_unf = 1'b0;
    end
    fifo_empty = (fq.size() == 0);
    dout_ready = rdy_drv;
    #1;
    cyc++;
    if (rst_drv) begin
      chk("rd_en_in_rst", 32'(fifo_rd_en), 32'(0));
      fq.delete();
      exp_q.delete();
      exp_words = 0;
      exp_err = 1'b0;
      rd_prev = 1'b0;
      n_reads = 0;
      n_pops = 0;
      after_rst = 1'b1;
    end else begin
      chk("words", words, 32'(exp_words));
      chk("err", 32'(err), 32'(exp_err));
      if (fifo_rd_en) begin
        chk("rd_en_when_empty", 32'(fifo_empty), 32'(0));
        n_reads++;
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", 32'(dout), 32'hFFFF_FFFF);
        else chk("dout", 32'(dout), 32'(exp_q.pop_front()));
        exp_words++;
        n_pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      chk("buffered_le_depth", 32'(n_reads - n_pops <= DEPTH), 32'(1));
      if (!after_rst && (fifo_underflow || (fifo_valid && !rd_prev))) exp_err = 1'b1;
      after_rst = 1'b0;
      rd_prev = fifo_rd_en;
    end
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    cycle();
    rst_drv = 1'b0;
  endtask

  logic [7:0] w0;
  int reads_bp;

  initial begin
    tbl[0] = '{1'b0,1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b0,32'd0};
    tbl[1] = '{1'b0,1'b1,1'b1,8'h11,1'b0, 1'b1,1'b0,8'h00,1'b0,32'd0};
    tbl[2] = '{1'b0,1'b1,1'b1,8'h22,1'b0, 1'b1,1'b1,8'h11,1'b0,32'd0};
    tbl[3] = '{1'b1,1'b1,1'b1,8'h33,1'b0, 1'b0,1'b1,8'h22,1'b0,32'd1};
    tbl[4] = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b1,8'h33,1'b0,32'd2};
    tbl[5] = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b0,32'd3};
    tbl[6] = '{1'b1,1'b1,1'b1,8'hAA,1'b0, 1'b0,1'b0,8'h00,1'b0,32'd3};
    tbl[7] = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b1,8'hAA,1'b1,32'd3};
    tbl[8] = '{1'b1,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b1,32'd4};

    rst = 1'b1;
    fifo_dout = '0;
    fifo_empty = 1'b1;
    fifo_valid = 1'b0;
    fifo_underflow = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'(0));
    chk("rst_dout_valid", 32'(dout_valid), 32'(0));
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_words", words, 32'(0));

    // Basic transfer then an unsolicited word, cycle by cycle.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      fifo_empty = tbl[i].empty;
      dout_ready = tbl[i].rdy;
      fifo_valid = tbl[i].vld;
      fifo_dout = tbl[i].dat;
      fifo_underflow = tbl[i].unf;
      #1;
      chk($sformatf("tbl%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_dv", i), 32'(dout_valid), 32'(tbl[i].e_dv));
      if (tbl[i].e_dv) chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_words", i), words, tbl[i].e_words);
    end

    // Backpressure: two reads fill the buffer, head holds, then full-rate drain.
    do_reset();
    load(10, 8'h40);
    w0 = 8'h40;
    rdy_drv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (dout_valid) chk("bp_hold", 32'(dout), 32'(w0));
    end
    reads_bp = n_reads;
    chk("bp_reads", 32'(reads_bp), 32'(2));
    chk("bp_rd_en_low", 32'(fifo_rd_en), 32'(0));
    chk("bp_dv", 32'(dout_valid), 32'(1));
    rdy_drv = 1'b1;
    first_pop = -1;
    for (int i = 0; i < 14; i++) cycle();
    chk("bp_pops", 32'(n_pops), 32'(10));
    chk("bp_no_gaps", 32'(last_pop - first_pop + 1), 32'(10));
    chk("bp_drained", 32'(exp_q.size()), 32'(0));

    // Alternating ready.
    do_reset();
    load(8, 8'h80);
    for (int i = 0; i < 24; i++) begin
      rdy_drv = i[0];
      cycle();
    end
    chk("alt_pops", 32'(n_pops), 32'(8));
    chk("alt_drained", 32'(exp_q.size()), 32'(0));
    chk("alt_err", 32'(err), 32'(0));

    // Empty FIFO, then an underflow pulse sets a sticky error.
    do_reset();
    rdy_drv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("empty_rd_en", 32'(fifo_rd_en), 32'(0));
      chk("empty_dv", 32'(dout_valid), 32'(0));
    end
    inj_unf = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("unf_sticky", 32'(err), 32'(1));

    // Reset mid-burst; stray valid right after reset is ignored.
    do_reset();
    load(20, 8'hC0);
    for (int i = 0; i < 6; i++) cycle();
    do_reset();
    inj_vld = 1'b1;
    inj_dat = 8'h5A;
    cycle();
    chk("post_rst_words", words, 32'(0));
    chk("post_rst_err", 32'(err), 32'(0));
    cycle();
    chk("post_rst_dv", 32'(dout_valid), 32'(0));
    chk("post_rst_err2", 32'(err), 32'(0));
    load(6, 8'h20);
    for (int i = 0; i < 12; i++) cycle();
    chk("post_rst_drained", 32'(exp_q.size()), 32'(0));
    chk("post_rst_words2", words, 32'(6));

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rdy_drv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          w0 = 8'($urandom);
          fq.push_back(w0);
          exp_q.push_back(w0);
        end
      end
      cycle();
    end
    rdy_drv = 1'b1;
    for (int i = 0; i < 60; i++) cycle();
    chk("rand_drained", 32'(exp_q.size()), 32'(0));
    chk("rand_words", words, 32'(exp_words));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
